// File: rtl/controller_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : controller_sequencer
// Description : SAP-1 controller-sequencer. A one-hot six-state ring counter
//               (T1..T6) is decoded against the instruction opcode nibble
//               into the 12-bit control word CON:
//               {CP,EP,LM_BAR,CE_BAR,LI_BAR,EI_BAR,LA_BAR,EA,SU,EU,LB_BAR,LO_BAR}
//               Fetch (T1..T3) is fixed. Execute (T4..T6) depends on the
//               opcode. HLT freezes the ring at T4 until CLR.
//               Optional feature macro: SAP_SINGLE_STEP_EN adds MANUAL/STEP
//               inputs for single-stepping the ring one state per STEP pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module controller_sequencer #(
    parameter logic [3:0] OPC_LDA = 4'h0,
    parameter logic [3:0] OPC_ADD = 4'h1,
    parameter logic [3:0] OPC_SUB = 4'h2,
    parameter logic [3:0] OPC_OUT = 4'hE,
    parameter logic [3:0] OPC_HLT = 4'hF
) (
    input  logic        CLK,
    input  logic        CLR,
`ifdef SAP_SINGLE_STEP_EN
    input  logic        MANUAL,
    input  logic        STEP,
`endif
    input  logic [3:0]  OPCODE,
    output logic [5:0]  T,
    output logic [11:0] CON,
    output logic        HLT
);

    // ------------------------------------------------------------------------
    // Ring states (one-hot, T[0]=T1 .. T[5]=T6)
    // ------------------------------------------------------------------------
    localparam logic [5:0] c_T1 = 6'b000001;
    localparam logic [5:0] c_T2 = 6'b000010;
    localparam logic [5:0] c_T3 = 6'b000100;
    localparam logic [5:0] c_T4 = 6'b001000;
    localparam logic [5:0] c_T5 = 6'b010000;
    localparam logic [5:0] c_T6 = 6'b100000;

    // ------------------------------------------------------------------------
    // Control words. Active-low lines sit high in the idle word, so 3E3 is
    // "nothing drives the bus, nothing loads, PC does not count".
    // ------------------------------------------------------------------------
    localparam logic [11:0] c_CON_NOP      = 12'h3E3;
    localparam logic [11:0] c_CON_PC_MAR   = 12'h5E3; // EP, LM_BAR low
    localparam logic [11:0] c_CON_PC_INC   = 12'hBE3; // CP
    localparam logic [11:0] c_CON_RAM_IR   = 12'h263; // CE_BAR, LI_BAR low
    localparam logic [11:0] c_CON_IR_MAR   = 12'h1A3; // EI_BAR, LM_BAR low
    localparam logic [11:0] c_CON_RAM_A    = 12'h2C3; // CE_BAR, LA_BAR low
    localparam logic [11:0] c_CON_RAM_B    = 12'h2E1; // CE_BAR, LB_BAR low
    localparam logic [11:0] c_CON_SUM_A    = 12'h3C7; // EU, LA_BAR low
    localparam logic [11:0] c_CON_DIFF_A   = 12'h3CF; // EU, SU, LA_BAR low
    localparam logic [11:0] c_CON_A_OUT    = 12'h3F2; // EA, LO_BAR low

    logic [5:0]  r_ring;
    logic        r_halted;
    logic        w_ring_ok;
    logic [5:0]  w_ring_next;
    logic        w_halt_req;
    logic        w_advance;
    logic [11:0] w_con_dec;

    // ------------------------------------------------------------------------
    // Ring bookkeeping. A non-one-hot ring cannot arise from reset and the
    // rotate path, but if it ever does the next edge snaps it back to T1.
    // ------------------------------------------------------------------------
    assign w_ring_ok   = (r_ring != 6'b000000) &&
                         ((r_ring & (r_ring - 6'd1)) == 6'b000000);
    assign w_ring_next = {r_ring[4:0], r_ring[5]};

    // Halt is requested while sitting in T4 with the HLT opcode latched in IR.
    assign w_halt_req  = (r_ring == c_T4) && (OPCODE == OPC_HLT) && !r_halted;

`ifdef SAP_SINGLE_STEP_EN
    logic r_step_d;

    // Remember last STEP level so each pulse produces exactly one advance.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= STEP;
        end
    end

    // In manual mode the ring moves only on a fresh STEP rising edge.
    assign w_advance = !MANUAL || (STEP && !r_step_d);
`else
    assign w_advance = 1'b1;
`endif

    // Ring counter and halted flag; reset beats halt, halt beats advance.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_ring   <= c_T1;
            r_halted <= 1'b0;
        end else if (r_halted) begin
            r_ring   <= r_ring;
        end else if (w_halt_req) begin
            r_halted <= 1'b1;
        end else if (!w_ring_ok) begin
            r_ring   <= c_T1;
        end else if (w_advance) begin
            r_ring   <= w_ring_next;
        end
    end

    // Decode ring state and opcode into the raw control word.
    always_comb begin
        w_con_dec = c_CON_NOP;
        case (r_ring)
            c_T1: w_con_dec = c_CON_PC_MAR;
            c_T2: w_con_dec = c_CON_PC_INC;
            c_T3: w_con_dec = c_CON_RAM_IR;
            c_T4: begin
                if ((OPCODE == OPC_LDA) || (OPCODE == OPC_ADD) ||
                    (OPCODE == OPC_SUB)) begin
                    w_con_dec = c_CON_IR_MAR;
                end else if (OPCODE == OPC_OUT) begin
                    w_con_dec = c_CON_A_OUT;
                end
            end
            c_T5: begin
                if (OPCODE == OPC_LDA) begin
                    w_con_dec = c_CON_RAM_A;
                end else if ((OPCODE == OPC_ADD) || (OPCODE == OPC_SUB)) begin
                    w_con_dec = c_CON_RAM_B;
                end
            end
            c_T6: begin
                if (OPCODE == OPC_ADD) begin
                    w_con_dec = c_CON_SUM_A;
                end else if (OPCODE == OPC_SUB) begin
                    w_con_dec = c_CON_DIFF_A;
                end
            end
            default: w_con_dec = c_CON_NOP;
        endcase
    end

    // Reset and halt both force the bus idle so the PC neither counts nor drives.
    assign CON = (CLR || r_halted) ? c_CON_NOP : w_con_dec;
    assign HLT = !CLR && (r_halted || w_halt_req);
    assign T   = r_ring;

endmodule
`default_nettype wire

// File: tb/tb_controller_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_controller_sequencer
// Description : Self-checking bench for controller_sequencer. A behavioural
//               model (state number 1..6 plus halted flag) predicts T, CON
//               and HLT every cycle; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controller_sequencer;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic [3:0]  OPCODE = 4'h0;
    logic [5:0]  T;
    logic [11:0] CON;
    logic        HLT;
`ifdef SAP_SINGLE_STEP_EN
    logic        MANUAL = 1'b0;
    logic        STEP = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    int m_t = 1;
    bit m_halt = 1'b0;
    bit m_valid = 1'b0;
    bit m_step_prev = 1'b0;
    bit m_adv;

    logic [3:0] picks [4] = '{4'h0, 4'h1, 4'h2, 4'hE};

    controller_sequencer dut (
        .CLK    (CLK),
        .CLR    (CLR),
`ifdef SAP_SINGLE_STEP_EN
        .MANUAL (MANUAL),
        .STEP   (STEP),
`endif
        .OPCODE (OPCODE),
        .T      (T),
        .CON    (CON),
        .HLT    (HLT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [11:0] got,
                         input logic [11:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Expected control word from the SAP-1 microprogram table.
    function automatic logic [11:0] exp_con(input int t, input logic [3:0] op);
        logic [35:0] tab;
        if (t == 1) return 12'h5E3;
        if (t == 2) return 12'hBE3;
        if (t == 3) return 12'h263;
        case (op)
            4'h0:    tab = {12'h1A3, 12'h2C3, 12'h3E3};
            4'h1:    tab = {12'h1A3, 12'h2E1, 12'h3C7};
            4'h2:    tab = {12'h1A3, 12'h2E1, 12'h3CF};
            4'hE:    tab = {12'h3F2, 12'h3E3, 12'h3E3};
            default: tab = {12'h3E3, 12'h3E3, 12'h3E3};
        endcase
        return tab[(6 - t) * 12 +: 12];
    endfunction

    // Model: advance the abstract machine at each rising edge.
    always @(posedge CLK) begin
        if (CLR) begin
            m_t = 1;
            m_halt = 1'b0;
            m_valid = 1'b1;
            m_step_prev = 1'b0;
        end else if (m_valid) begin
`ifdef SAP_SINGLE_STEP_EN
            m_adv = !MANUAL || (STEP && !m_step_prev);
            m_step_prev = STEP;
`else
            m_adv = 1'b1;
`endif
            if (m_halt) begin
                m_halt = 1'b1;
            end else if (m_t == 4 && OPCODE == 4'hF) begin
                m_halt = 1'b1;
            end else if (m_adv) begin
                m_t = (m_t == 6) ? 1 : m_t + 1;
            end
        end
    end

    // Compare: every falling edge once the model has seen a reset.
    always @(negedge CLK) begin
        if (m_valid) begin
            logic eh;
            eh = !CLR && (m_halt || (m_t == 4 && OPCODE == 4'hF));
            check("model_T", {6'd0, T}, 12'd1 << (m_t - 1));
            check("model_HLT", {11'd0, HLT}, {11'd0, eh});
            check("model_CON", CON, (CLR || m_halt) ? 12'h3E3 : exp_con(m_t, OPCODE));
        end
    end

    task automatic drive(input logic clr, input logic [3:0] opc);
        @(posedge CLK);
        #1;
        CLR = clr;
        OPCODE = opc;
        @(negedge CLK);
    endtask

    // Run from T1 through T2..T6 and back to T1, pinning execute words.
    task automatic instr(input logic [3:0] fetch_opc, input logic [3:0] opc,
                         input logic [11:0] e4, input logic [11:0] e5,
                         input logic [11:0] e6);
        drive(1'b0, fetch_opc); check("fetch_T2", CON, 12'hBE3);
        drive(1'b0, fetch_opc); check("fetch_T3", CON, 12'h263);
        drive(1'b0, opc);       check("exec_T4", CON, e4);
        drive(1'b0, opc);       check("exec_T5", CON, e5);
        drive(1'b0, opc);       check("exec_T6", CON, e6);
        drive(1'b0, opc);       check("wrap_T1", CON, 12'h5E3);
    endtask

    initial begin
        logic [11:0] lda_seq [7];
        lda_seq = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3, 12'h5E3};

        // Reset held for two edges
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h0);
        check("rst_T", {6'd0, T}, 12'h001);
        check("rst_CON", CON, 12'h3E3);
        check("rst_HLT", {11'd0, HLT}, 12'h000);

        // Release and walk one full LDA instruction plus wrap
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 4'h0);
            check("lda_seq", CON, lda_seq[i]);
        end

        instr(4'h1, 4'h1, 12'h1A3, 12'h2E1, 12'h3C7);   // ADD
        instr(4'hF, 4'h2, 12'h1A3, 12'h2E1, 12'h3CF);   // SUB, HLT nibble in fetch
        instr(4'h5, 4'hE, 12'h3F2, 12'h3E3, 12'h3E3);   // OUT
        instr(4'h2, 4'h7, 12'h3E3, 12'h3E3, 12'h3E3);   // undefined opcode

        // Halt at T4, stay frozen, exit only through CLR
        drive(1'b0, 4'hF);
        drive(1'b0, 4'hF);
        drive(1'b0, 4'hF);
        check("hlt_T4_HLT", {11'd0, HLT}, 12'h001);
        check("hlt_T4_CON", CON, 12'h3E3);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 4'($urandom_range(0, 15)));
            check("halted_T", {6'd0, T}, 12'h008);
            check("halted_HLT", {11'd0, HLT}, 12'h001);
        end
        drive(1'b1, 4'h0);
        check("hlt_clr_HLT", {11'd0, HLT}, 12'h000);
        check("hlt_clr_CON", CON, 12'h3E3);
        drive(1'b0, 4'h0);
        check("hlt_exit_T", {6'd0, T}, 12'h001);
        check("hlt_exit_CON", CON, 12'h5E3);

        // Mid-instruction reset during T5 of ADD
        drive(1'b0, 4'h1);
        drive(1'b0, 4'h1);
        drive(1'b0, 4'h1);
        drive(1'b1, 4'h1);
        check("mid_T5", {6'd0, T}, 12'h010);
        check("mid_CON_a", CON, 12'h3E3);
        drive(1'b1, 4'h1);
        check("mid_T1", {6'd0, T}, 12'h001);
        check("mid_CON_b", CON, 12'h3E3);
        drive(1'b0, 4'h0);
        check("mid_rel_CON", CON, 12'h5E3);

`ifdef SAP_SINGLE_STEP_EN
        // Manual mode: hold without STEP, then three single-cycle pulses
        drive(1'b1, 4'h0);
        MANUAL = 1'b1;
        drive(1'b0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'h0);
            check("manual_hold_T", {6'd0, T}, 12'h001);
        end
        for (int k = 0; k < 3; k++) begin
            STEP = 1'b1;
            drive(1'b0, 4'h0);
            STEP = 1'b0;
            drive(1'b0, 4'h0);
            drive(1'b0, 4'h0);
        end
        drive(1'b0, 4'h0);
        check("manual_step3_T", {6'd0, T}, 12'h008);
        MANUAL = 1'b0;
`endif

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            logic        clr;
            logic [3:0]  opc;
            int          r;
            clr = ($urandom_range(0, 39) == 0);
            r = int'($urandom_range(0, 7));
            opc = (r < 5) ? picks[r % 4] : 4'($urandom_range(0, 15));
`ifdef SAP_SINGLE_STEP_EN
            MANUAL = ($urandom_range(0, 3) == 0);
            STEP = 1'($urandom_range(0, 1));
`endif
            drive(clr, opc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
